// File: rtl/rids_bitonic_feeder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rids_bitonic_feeder_pkg
//  Description : Shared widths, types and the RIDS element-reversal helper
//                for the bitonic feeder.
//  Revision    : 1.0  initial release
// ============================================================================
package rids_bitonic_feeder_pkg;

    localparam int NUM_RULE_ID = 8;
    localparam int RID_W       = 4;
    localparam int RIDS_WIDTH  = NUM_RULE_ID * RID_W;
    localparam int TAG_W       = 8;

    typedef logic [0:RIDS_WIDTH-1]   rids_t;
    typedef logic [0:2*RIDS_WIDTH-1] word_t;
    typedef logic [TAG_W-1:0]        tag_t;

    // Half the tag space; a forward distance up to this value marks A as older.
    localparam tag_t TAG_HALF = tag_t'(1 << (TAG_W - 1));

    // Reverse element order: element i of the result is element N-1-i of x.
    function automatic rids_t rids_reverse(input rids_t x);
        rids_t r;
        r = '0;
        for (int i = 0; i < NUM_RULE_ID; i++) begin
            r[i*RID_W +: RID_W] = x[(NUM_RULE_ID-1-i)*RID_W +: RID_W];
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rids_bitonic_feeder_if.sv
`default_nettype none
// ============================================================================
//  Module      : rids_bitonic_feeder_if
//  Description : Input channels A/B, bitonic output and error status bundle.
//  Revision    : 1.0  initial release
// ============================================================================
interface rids_bitonic_feeder_if;
    import rids_bitonic_feeder_pkg::*;

    logic       a_valid;
    logic       a_ready;
    rids_t      a_rids;
    tag_t       a_tag;
    logic       b_valid;
    logic       b_ready;
    rids_t      b_rids;
    tag_t       b_tag;
    logic       out_valid;
    logic       out_ready;
    word_t      out_data;
    tag_t       out_tag;
    logic       tag_err;
    logic [7:0] err_cnt;

    modport master (
        output a_valid, a_rids, a_tag, b_valid, b_rids, b_tag, out_ready,
        input  a_ready, b_ready, out_valid, out_data, out_tag, tag_err, err_cnt
    );

    modport slave (
        input  a_valid, a_rids, a_tag, b_valid, b_rids, b_tag, out_ready,
        output a_ready, b_ready, out_valid, out_data, out_tag, tag_err, err_cnt
    );

endinterface
`default_nettype wire

// File: rtl/rids_bitonic_feeder_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : rids_fifo
//  Description : Synchronous FIFO with first-word-fall-through head output.
//                Pushes into a full FIFO are ignored even when popping.
//  Revision    : 1.0  initial release
// ============================================================================
module rids_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 4
) (
    input  wire logic             clk,
    input  wire logic             reset_n,
    input  wire logic             push,
    input  wire logic [WIDTH-1:0] din,
    input  wire logic             pop,
    output logic      [WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty
);
    localparam int c_PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic               w_push;
    logic               w_pop;

    assign full   = (r_count == (c_PTR_W+1)'(DEPTH));
    assign empty  = (r_count == '0);
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;
    assign dout   = r_mem[r_rd_ptr];

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/rids_bitonic_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : rids_bitonic_feeder
//  Description : Buffers channel A/B RIDS, pairs heads by packet tag, drops
//                the older head on mismatch, and emits {A, reverse(B)} as a
//                bitonic word on a valid/ready output.
//  Revision    : 1.0  initial release
// ============================================================================
module rids_bitonic_feeder
    import rids_bitonic_feeder_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic              clk,
    input  wire logic              reset_n,
    rids_bitonic_feeder_if.slave   bus
);
    localparam int c_FIFO_W = RIDS_WIDTH + TAG_W;

    logic [c_FIFO_W-1:0] w_a_head;
    logic [c_FIFO_W-1:0] w_b_head;
    logic                w_a_full;
    logic                w_a_empty;
    logic                w_b_full;
    logic                w_b_empty;
    rids_t               w_a_rids;
    rids_t               w_b_rids;
    tag_t                w_a_tag;
    tag_t                w_b_tag;
    tag_t                w_tag_diff;
    logic                w_fire;
    logic                w_match;
    logic                w_a_older;
    logic                w_pop_a;
    logic                w_pop_b;

    logic                r_alive;
    logic                r_out_valid;
    word_t               r_out_data;
    tag_t                r_out_tag;
    logic                r_tag_err;
    logic [7:0]          r_err_cnt;

    rids_fifo #(.WIDTH(c_FIFO_W), .DEPTH(FIFO_DEPTH)) u_fifo_a (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (bus.a_valid && bus.a_ready),
        .din     ({bus.a_tag, bus.a_rids}),
        .pop     (w_pop_a),
        .dout    (w_a_head),
        .full    (w_a_full),
        .empty   (w_a_empty)
    );

    rids_fifo #(.WIDTH(c_FIFO_W), .DEPTH(FIFO_DEPTH)) u_fifo_b (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (bus.b_valid && bus.b_ready),
        .din     ({bus.b_tag, bus.b_rids}),
        .pop     (w_pop_b),
        .dout    (w_b_head),
        .full    (w_b_full),
        .empty   (w_b_empty)
    );

    assign {w_a_tag, w_a_rids} = w_a_head;
    assign {w_b_tag, w_b_rids} = w_b_head;

    // Ready is held low through reset and for the edge that releases it.
    assign bus.a_ready = r_alive && !w_a_full;
    assign bus.b_ready = r_alive && !w_b_full;

    // Pairing needs both heads and an output slot that is free or draining.
    assign w_fire     = !w_a_empty && !w_b_empty && (!r_out_valid || bus.out_ready);
    assign w_match    = (w_a_tag == w_b_tag);
    assign w_tag_diff = w_b_tag - w_a_tag;
    assign w_a_older  = (w_tag_diff != '0) && (w_tag_diff <= TAG_HALF);
    assign w_pop_a    = w_fire && (w_match || w_a_older);
    assign w_pop_b    = w_fire && (w_match || !w_a_older);

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_tag   = r_out_tag;
    assign bus.tag_err   = r_tag_err;
    assign bus.err_cnt   = r_err_cnt;

    // Marks the first clock after reset release so the channels open up.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_alive <= 1'b0;
        end else begin
            r_alive <= 1'b1;
        end
    end

    // Output register: load a matched pair, otherwise drain when accepted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_tag   <= '0;
        end else if (w_fire && w_match) begin
            r_out_valid <= 1'b1;
            r_out_data  <= {w_a_rids, rids_reverse(w_b_rids)};
            r_out_tag   <= w_a_tag;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Drop pulse and saturating drop counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tag_err <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_tag_err <= w_fire && !w_match;
            if (w_fire && !w_match && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

endmodule
`default_nettype wire
